// File: rtl/frame_ring_buffer_if.sv
// Camera-side pixel stream and reader-side frame access for frame_ring_buffer.
// pixel_valid qualifies pixel_data with no backpressure; rd_acquire/rd_release are sampled every clock, effect visible next cycle.
interface frame_ring_buffer_if #(
    parameter int PIXEL_BITS = 1,
    parameter int NUM_BUFS   = 3,
    parameter int ADDR_WIDTH = 14
);
    localparam int IDX_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;

    logic                  frame_start;
    logic                  pixel_valid;
    logic [PIXEL_BITS-1:0] pixel_data;
    logic                  rd_acquire;
    logic                  rd_release;
    logic                  rd_valid;
    logic [IDX_W-1:0]      rd_buf_idx;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [15:0]           rd_data;
    logic                  frame_done;
    logic                  frame_dropped;
    logic                  frame_short;
    logic [1:0]            dbg_wr_state;

    modport master (
        output frame_start, pixel_valid, pixel_data, rd_acquire, rd_release, rd_addr,
        input  rd_valid, rd_buf_idx, rd_data, frame_done, frame_dropped, frame_short, dbg_wr_state
    );

    modport slave (
        input  frame_start, pixel_valid, pixel_data, rd_acquire, rd_release, rd_addr,
        output rd_valid, rd_buf_idx, rd_data, frame_done, frame_dropped, frame_short, dbg_wr_state
    );
endinterface

// File: rtl/frame_ring_buffer.sv
// N-bank camera frame store: packs pixels into 16-bit words and hands the newest
// complete frame to a reader that explicitly acquires and releases it.
module frame_ring_buffer #(
    parameter int H_PIXELS   = 320,
    parameter int V_LINES    = 240,
    parameter int PIXEL_BITS = 1,
    parameter int NUM_BUFS   = 3,
    parameter int ADDR_WIDTH = 14
) (
    input  logic               cam_pclk,
    input  logic               rst_n,
    frame_ring_buffer_if.slave bus
);
    localparam int FRAME_PIXELS = H_PIXELS * V_LINES;
    localparam int PPW          = 16 / PIXEL_BITS;
    localparam int WORDS        = (FRAME_PIXELS * PIXEL_BITS + 15) / 16;
    localparam int IDX_W        = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam int WA           = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PIX_W        = $clog2(FRAME_PIXELS + 1);
    localparam int SLOT_W       = 5;

    typedef enum logic [1:0] {B_FREE, B_WRITING, B_READY, B_READING} bank_state_e;
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FLUSH} wr_state_e;

    wr_state_e   r_state;
    wr_state_e   w_state_nxt;
    bank_state_e r_bank     [NUM_BUFS];
    bank_state_e w_bank_nxt [NUM_BUFS];

    logic [IDX_W-1:0]  r_wr_bank;
    logic [PIX_W-1:0]  r_pix_cnt;
    logic [WA-1:0]     r_word_cnt;
    logic [SLOT_W-1:0] r_slot;
    logic [15:0]       r_pack;
    logic              r_wr_pend;
    logic [WA-1:0]     r_wr_addr;
    logic [15:0]       r_wr_word;

    logic              r_rd_valid;
    logic [IDX_W-1:0]  r_rd_buf;
    logic [15:0]       r_rd_data;
    logic              r_frame_done;
    logic              r_frame_dropped;
    logic              r_frame_short;

    logic [15:0]       r_mem [NUM_BUFS][WORDS];

    logic              w_accept;
    logic              w_commit;
    logic              w_short;
    logic              w_last;
    logic              w_word_full;
    logic [15:0]       w_pack_nxt;
    logic              w_drop;
    logic              w_sel_ok;
    logic              w_reclaim;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_rd_take;
    logic [IDX_W-1:0]  w_take_idx;
    logic              w_rel;
    logic              w_rd_hold;
    logic [WA-1:0]     w_rd_word;
    logic              w_rd_in_range;

    // ---------------- write FSM ----------------
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.frame_start) begin
            w_state_nxt = w_sel_ok ? S_WRITE : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_WRITE: if (w_last) w_state_nxt = S_FLUSH;
                S_FLUSH: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // frame_start owns its cycle: any pixel alongside it is not part of either frame
    always_comb begin
        w_accept = (r_state == S_WRITE) && bus.pixel_valid && !bus.frame_start;
        w_commit = (r_state == S_FLUSH);
        w_short  = (r_state == S_WRITE) && bus.frame_start;
    end

    assign w_last      = w_accept && (r_pix_cnt == PIX_W'(FRAME_PIXELS - 1));
    assign w_word_full = (r_slot == SLOT_W'(PPW - 1)) || w_last;
    assign w_pack_nxt  = r_pack | (16'(bus.pixel_data) << (32'(r_slot) * PIXEL_BITS));

    // ---------------- pixel packing ----------------
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank  <= '0;
            r_pix_cnt  <= '0;
            r_word_cnt <= '0;
            r_slot     <= '0;
            r_pack     <= '0;
            r_wr_pend  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_word  <= '0;
        end else begin
            r_wr_pend <= 1'b0;
            if (bus.frame_start && w_sel_ok) begin
                r_wr_bank  <= w_sel_idx;
                r_pix_cnt  <= '0;
                r_word_cnt <= '0;
                r_slot     <= '0;
                r_pack     <= '0;
            end else if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                if (w_word_full) begin
                    r_wr_pend  <= 1'b1;
                    r_wr_word  <= w_pack_nxt;
                    r_wr_addr  <= r_word_cnt;
                    r_word_cnt <= r_word_cnt + WA'(1);
                    r_slot     <= '0;
                    r_pack     <= '0;
                end else begin
                    r_pack <= w_pack_nxt;
                    r_slot <= r_slot + SLOT_W'(1);
                end
            end
        end
    end

    // ---------------- bank state arbitration ----------------
    // Order matters: commit/abort first, then the reader takes the newest READY,
    // then a new frame picks a bank, and only last does a released bank turn FREE.
    assign w_rel = bus.rd_release && r_rd_valid;

    always_comb begin
        w_bank_nxt = r_bank;
        w_drop     = 1'b0;
        w_sel_ok   = 1'b0;
        w_reclaim  = 1'b0;
        w_sel_idx  = '0;
        w_rd_take  = 1'b0;
        w_take_idx = '0;

        if (w_commit) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                if (r_bank[i] == B_READY) begin
                    w_bank_nxt[i] = B_FREE;
                    w_drop        = 1'b1;
                end
            end
            w_bank_nxt[r_wr_bank] = B_READY;
        end else if (w_short) begin
            w_bank_nxt[r_wr_bank] = B_FREE;
        end

        if (bus.rd_acquire && (!r_rd_valid || bus.rd_release)) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                if (w_bank_nxt[i] == B_READY) begin
                    w_rd_take  = 1'b1;
                    w_take_idx = IDX_W'(i);
                end
            end
            if (w_rd_take) w_bank_nxt[w_take_idx] = B_READING;
        end

        if (bus.frame_start) begin
            for (int i = NUM_BUFS - 1; i >= 0; i--) begin
                if (w_bank_nxt[i] == B_FREE) begin
                    w_sel_ok  = 1'b1;
                    w_sel_idx = IDX_W'(i);
                end
            end
            if (!w_sel_ok) begin
                for (int i = 0; i < NUM_BUFS; i++) begin
                    if (w_bank_nxt[i] == B_READY) begin
                        w_sel_ok  = 1'b1;
                        w_reclaim = 1'b1;
                        w_sel_idx = IDX_W'(i);
                    end
                end
            end
            if (w_sel_ok) w_bank_nxt[w_sel_idx] = B_WRITING;
            if (w_reclaim) w_drop = 1'b1;
        end

        if (w_rel) w_bank_nxt[r_rd_buf] = B_FREE;
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUFS; i++) r_bank[i] <= B_FREE;
            r_frame_done    <= 1'b0;
            r_frame_dropped <= 1'b0;
            r_frame_short   <= 1'b0;
        end else begin
            r_bank          <= w_bank_nxt;
            r_frame_done    <= w_commit;
            r_frame_dropped <= w_drop;
            r_frame_short   <= w_short;
        end
    end

    // ---------------- frame memory ----------------
    always_ff @(posedge cam_pclk) begin
        if (r_wr_pend) r_mem[r_wr_bank][r_wr_addr] <= r_wr_word;
    end

    // ---------------- read side ----------------
    // rd_data follows the bank held during the read, and is zeroed once the hold ends.
    assign w_rd_hold     = w_rd_take || (r_rd_valid && !w_rel);
    assign w_rd_word     = WA'(bus.rd_addr);
    assign w_rd_in_range = 32'(bus.rd_addr) < 32'(WORDS);

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_buf   <= '0;
            r_rd_data  <= '0;
        end else begin
            if (w_rd_take) begin
                r_rd_valid <= 1'b1;
                r_rd_buf   <= w_take_idx;
            end else if (w_rel) begin
                r_rd_valid <= 1'b0;
            end
            r_rd_data <= (r_rd_valid && w_rd_hold && w_rd_in_range) ?
                         r_mem[r_rd_buf][w_rd_word] : 16'h0000;
        end
    end

    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_buf_idx    = r_rd_buf;
    assign bus.rd_data       = r_rd_data;
    assign bus.frame_done    = r_frame_done;
    assign bus.frame_dropped = r_frame_dropped;
    assign bus.frame_short   = r_frame_short;
    assign bus.dbg_wr_state  = r_state;

endmodule
